// File: rtl/mux41_rr_arbiter.sv
// Round-robin arbiter that shares one 4:1 mux among four requesters.
// A hold timer bounds each tenure so that no requester starves the others.
module mux41_rr_arbiter #(
   parameter int HOLD_MAX = 8,
   parameter int CNT_W    = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [3:0] req,
   output logic [3:0] gnt,
   output logic       s1,
   output logic       s0,
   output logic       sel_valid
);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t             state, state_nx;
   logic [1:0]         ptr, ptr_nx;
   logic [1:0]         sel, sel_nx;
   logic [CNT_W-1:0]   hold_cnt, hold_nx;
   logic [3:0]         gnt_nx;

   logic [1:0]         pick_start;
   logic [1:0]         pick_idx;
   logic [1:0]         cand;
   logic               pick_found;
   logic               release_owner;

   // The owner is always sel. On release the scan starts just past the owner.
   // An expired owner that is still requesting is therefore reached last.
   assign release_owner = (state == GRANT) &&
                          (!req[sel] || (hold_cnt == CNT_W'(HOLD_MAX)));
   assign pick_start    = (state == GRANT) ? sel + 2'd1 : ptr;

   // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = pick_start;
      cand       = pick_start;
      for (int i = 0; i < 4; i++) begin
         cand = pick_start + 2'(i);
         if (!pick_found && req[cand]) begin
            pick_found = 1'b1;
            pick_idx   = cand;
         end
      end
   end

   always_comb begin
      state_nx = state;
      ptr_nx   = ptr;
      sel_nx   = sel;
      hold_nx  = hold_cnt;
      gnt_nx   = gnt;
      if (en) begin
         case (state)
            IDLE: begin
               if (pick_found) begin
                  state_nx = GRANT;
                  gnt_nx   = 4'b0001 << pick_idx;
                  sel_nx   = pick_idx;
                  hold_nx  = CNT_W'(1);
               end
            end
            GRANT: begin
               if (release_owner) begin
                  ptr_nx = sel + 2'd1;
                  if (pick_found) begin
                     gnt_nx  = 4'b0001 << pick_idx;
                     sel_nx  = pick_idx;
                     hold_nx = CNT_W'(1);
                  end else begin
                     state_nx = IDLE;
                     gnt_nx   = 4'b0000;
                     hold_nx  = '0;
                  end
               end else begin
                  hold_nx = hold_cnt + CNT_W'(1);
               end
            end
            default: begin
               state_nx = IDLE;
               gnt_nx   = 4'b0000;
            end
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         ptr      <= 2'd0;
         sel      <= 2'd0;
         hold_cnt <= '0;
         gnt      <= 4'b0000;
      end else begin
         state    <= state_nx;
         ptr      <= ptr_nx;
         sel      <= sel_nx;
         hold_cnt <= hold_nx;
         gnt      <= gnt_nx;
      end
   end

   // sel keeps its last value while idle, so the mux select does not glitch.
   assign s1        = sel[1];
   assign s0        = sel[0];
   assign sel_valid = |gnt;

endmodule

// File: tb/tb_mux41_rr_arbiter.sv
// Self-checking bench for mux41_rr_arbiter: a queue-free behavioural model is
// compared every cycle, and directed scenarios carry literal expectations.
module tb_mux41_rr_arbiter;

   localparam int HOLD_MAX = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b1;
   logic [3:0] req = 4'hF;
   logic [3:0] gnt;
   logic       s1, s0, sel_valid;

   int total = 0;
   int bad   = 0;

   mux41_rr_arbiter #(.HOLD_MAX(HOLD_MAX), .CNT_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .req(req),
      .gnt(gnt), .s1(s1), .s0(s0), .sel_valid(sel_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: owner index (-1 = idle), pointer, tenure length.
   int m_own, m_ptr, m_hold, m_sel, m_win;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_own = -1; m_ptr = 0; m_hold = 0; m_sel = 0;
      end else if (en) begin
         if (m_own >= 0 && req[m_own] && m_hold < HOLD_MAX) begin
            m_hold = m_hold + 1;
         end else begin
            if (m_own >= 0) m_ptr = (m_own + 1) % 4;
            m_win = -1;
            for (int i = 0; i < 4; i++)
               if (m_win < 0 && req[(m_ptr + i) % 4]) m_win = (m_ptr + i) % 4;
            m_own = m_win;
            if (m_win >= 0) begin
               m_hold = 1;
               m_sel  = m_win;
            end else begin
               m_hold = 0;
            end
         end
      end
   end

   always @(negedge clk) begin
      check("model_gnt", 32'(gnt), (m_own < 0) ? 32'd0 : (32'd1 << m_own));
      check("model_sel", 32'({s1, s0}), 32'(m_sel));
      check("model_valid", 32'(sel_valid), 32'(m_own >= 0));
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
   endtask

   logic [3:0] rot [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

   initial begin
      // Reset held with all requests high.
      tick(); tick();
      check("rst_gnt", 32'(gnt), 32'h0);
      check("rst_sel", 32'({s1, s0}), 32'h0);
      check("rst_valid", 32'(sel_valid), 32'h0);
      rst_n = 1'b1;
      tick();
      check("first_grant", 32'(gnt), 32'h1);

      // Single requester c held: re-granted on expiry, never released.
      req = 4'b0100;
      for (int n = 0; n < 21; n++) begin
         tick();
         check("hold_c_gnt", 32'(gnt), 32'h4);
         check("hold_c_sel", 32'({s1, s0}), 32'h2);
      end

      // All requesting: rotation every HOLD_MAX cycles, including the wrap.
      req = 4'hF;
      pulse_reset();
      for (int n = 1; n <= 33; n++) begin
         tick();
         check("rotate_gnt", 32'(gnt), 32'(rot[((n - 1) / HOLD_MAX) % 4]));
         check("rotate_sel", 32'({s1, s0}), 32'(((n - 1) / HOLD_MAX) % 4));
      end

      // Owner b drops while d waits: handover with no idle cycle.
      req = 4'b0010;
      pulse_reset();
      tick();
      check("b_owner", 32'(gnt), 32'h2);
      req = 4'b1010;
      tick();
      check("b_keeps", 32'(gnt), 32'h2);
      req = 4'b1000;
      tick();
      check("handover_gnt", 32'(gnt), 32'h8);
      check("handover_sel", 32'({s1, s0}), 32'h3);
      check("handover_valid", 32'(sel_valid), 32'h1);

      // Freeze mid-tenure: tenure resumes from the frozen count.
      req = 4'b0001;
      pulse_reset();
      tick(); tick(); tick();
      en = 1'b0;
      for (int n = 0; n < 5; n++) begin
         req = 4'(n * 3 + 2);
         tick();
         check("frozen_gnt", 32'(gnt), 32'h1);
         check("frozen_sel", 32'({s1, s0}), 32'h0);
      end
      en  = 1'b1;
      req = 4'b0011;
      for (int n = 0; n < 5; n++) begin
         tick();
         check("resume_gnt", 32'(gnt), 32'h1);
      end
      tick();
      check("resume_expire", 32'(gnt), 32'h2);

      // Asynchronous reset between edges drops the grant immediately.
      req = 4'b0100;
      tick(); tick();
      rst_n = 1'b0;
      #1;
      check("async_gnt", 32'(gnt), 32'h0);
      check("async_valid", 32'(sel_valid), 32'h0);
      req = 4'b1010;
      #1;
      rst_n = 1'b1;
      tick();
      check("post_rst_gnt", 32'(gnt), 32'h2);
      check("post_rst_sel", 32'({s1, s0}), 32'h1);

      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
